// File: rtl/ddr_ins_pkg.sv
// Shared opcodes, instruction field positions and arbiter state encoding
// for the DDR instruction-port arbiter.
package ddr_ins_pkg;

  localparam logic [3:0] OPC_RD   = 4'd1;
  localparam logic [3:0] OPC_WR   = 4'd2;
  localparam int         OPC_LSB  = 0;
  localparam int         OPC_MSB  = 3;
  localparam int         ADDR_LSB = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ddr_rr_pick.sv
// Rotate-priority picker: first asserted request at or after i_rr_ptr,
// wrapping at NUM_REQ. Purely combinational.
module ddr_rr_pick #(
  parameter  int NUM_REQ = 3,
  localparam int SRC_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [SRC_W-1:0]   i_rr_ptr,
  output logic [SRC_W-1:0]   o_gnt_id,
  output logic               o_any_req
);

  // Scan from the farthest slot back to the pointer so the nearest hit wins last.
  always_comb begin
    int idx;
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    o_gnt_id  = '0;
    o_any_req = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(i_rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (i_req[idx]) begin
        o_gnt_id  = SRC_W'(idx);
        o_any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_ins_arbiter.sv
// Round-robin burst arbiter for the single DDR-controller instruction port,
// with a one-deep output register and an outstanding-read credit counter.
module ddr_ins_arbiter
  import ddr_ins_pkg::*;
#(
  parameter  int NUM_REQ         = 3,
  parameter  int INS_W           = 32,
  parameter  int MAX_OUTSTANDING = 16,
  localparam int SRC_W           = $clog2(NUM_REQ),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                     clk_200M,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       i_req_ins_vld,
  input  logic [NUM_REQ*INS_W-1:0] i_req_ins,
  input  logic [NUM_REQ-1:0]       i_req_ins_last,
  output logic [NUM_REQ-1:0]       o_req_ins_rdy,
  output logic                     o_ddr_ins_vld,
  output logic [INS_W-1:0]         o_ddr_ins,
  output logic [SRC_W-1:0]         o_ddr_ins_src,
  input  logic                     i_ddr_ins_rdy,
  input  logic                     i_ddr_rd_done,
  output logic [CNT_W-1:0]         o_rd_credit_cnt,
  output logic                     o_busy,
  output logic                     o_credit_err
);

  arb_state_e       r_state;
  logic [SRC_W-1:0] r_gnt_id;
  logic [SRC_W-1:0] r_rr_ptr;
  logic             r_ins_vld;
  logic [INS_W-1:0] r_ins;
  logic [SRC_W-1:0] r_ins_src;
  logic [CNT_W-1:0] r_credit;
  logic             r_credit_err;

  logic [SRC_W-1:0] w_pick_id;
  logic             w_any_req;
  logic [INS_W-1:0] w_gnt_ins;
  logic             w_is_rd;
  logic             w_slot_free;
  logic             w_credit_ok;
  logic             w_accept_en;
  logic             w_xfer;
  logic             w_xfer_last;
  logic             w_rd_inc;
  logic [SRC_W-1:0] w_next_ptr;

  ddr_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .i_req     (i_req_ins_vld),
    .i_rr_ptr  (r_rr_ptr),
    .o_gnt_id  (w_pick_id),
    .o_any_req (w_any_req)
  );

  assign w_gnt_ins   = i_req_ins[r_gnt_id*INS_W +: INS_W];
  assign w_is_rd     = (w_gnt_ins[OPC_MSB:OPC_LSB] == OPC_RD);
  assign w_slot_free = !r_ins_vld || i_ddr_ins_rdy;
  // Credit check uses the registered count, so a same-cycle rd_done frees the slot next cycle.
  assign w_credit_ok = !w_is_rd || (r_credit < CNT_W'(MAX_OUTSTANDING));
  assign w_accept_en = (r_state == GRANT) && w_slot_free && w_credit_ok;
  assign w_xfer      = w_accept_en && i_req_ins_vld[r_gnt_id];
  assign w_xfer_last = w_xfer && i_req_ins_last[r_gnt_id];
  assign w_rd_inc    = w_xfer && w_is_rd;
  assign w_next_ptr  = (r_gnt_id == SRC_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + 1'b1;

  always_comb begin
    o_req_ins_rdy = '0;
    if (w_accept_en) o_req_ins_rdy[r_gnt_id] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_gnt_id <= '0;
      r_rr_ptr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_gnt_id <= w_pick_id;
            r_state  <= GRANT;
          end
        end
        GRANT: begin
          // A granted source that drops vld keeps the grant; only its last beat releases it.
          if (w_xfer_last) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      r_ins_vld <= 1'b0;
      r_ins     <= '0;
      r_ins_src <= '0;
    end else if (w_xfer) begin
      r_ins_vld <= 1'b1;
      r_ins     <= w_gnt_ins;
      r_ins_src <= r_gnt_id;
    end else if (i_ddr_ins_rdy) begin
      r_ins_vld <= 1'b0;
    end
  end

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      r_credit     <= '0;
      r_credit_err <= 1'b0;
    end else begin
      case ({w_rd_inc, i_ddr_rd_done})
        2'b10: r_credit <= r_credit + 1'b1;
        2'b01: begin
          if (r_credit == '0) r_credit_err <= 1'b1;
          else                r_credit     <= r_credit - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_ddr_ins_vld   = r_ins_vld;
  assign o_ddr_ins       = r_ins;
  assign o_ddr_ins_src   = r_ins_src;
  assign o_rd_credit_cnt = r_credit;
  assign o_credit_err    = r_credit_err;
  assign o_busy          = (r_state != IDLE) || r_ins_vld;

endmodule
